// File: rtl/seq_detect_if.sv
// Serial sequence-detector bus: sampled inputs (en, clr, x) from the front end,
// match flag, prefix state and saturating match counter back to control logic.
interface seq_detect_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    localparam int STATE_W = $clog2(PAT_W + 1);

    logic               en;
    logic               clr;
    logic               x;
    logic               y;
    logic [STATE_W-1:0] state;
    logic [CNT_W-1:0]   match_cnt;
    logic               cnt_sat;

    modport master (
        output en, clr, x,
        input  y, state, match_cnt, cnt_sat
    );

    modport slave (
        input  en, clr, x,
        output y, state, match_cnt, cnt_sat
    );
endinterface

// File: rtl/seq_detect_fsm.sv
// Parametrised KMP serial pattern detector with selectable overlap and Mealy/Moore
// match flag, plus a saturating match counter. Transition table is built at elaboration.
module seq_detect_fsm #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter bit               MEALY   = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_detect_if.slave bus
);
    localparam int STATE_W = $clog2(PAT_W + 1);
    localparam int TAB_N   = 2 ** (STATE_W + 1);

    if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
        $error("seq_detect_fsm: PAT_W must be in 2..16");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_detect_fsm: CNT_W must be >= 1");
    end

    // Bit i of the pattern in arrival order (i = 0 is received first).
    function automatic bit pat_bit(input int i);
        return PATTERN[PAT_W-1-i];
    endfunction

    // Longest proper border of the full pattern: where an overlapping match resumes.
    function automatic int full_border();
        int  len;
        bit  ok;
        len = 0;
        for (int j = 1; j < PAT_W; j++) begin
            ok = 1'b1;
            for (int t = 0; t < j; t++) begin
                if (pat_bit(t) != pat_bit(PAT_W - j + t)) ok = 1'b0;
            end
            if (ok) len = j;
        end
        return len;
    endfunction

    localparam int BORDER  = full_border();
    localparam int RESTART = OVERLAP ? BORDER : 0;

    // Automaton step: longest pattern prefix that is a suffix of (prefix k) followed by b.
    // State PAT_W (Moore hold cycle) behaves as the restart state; codes above PAT_W are unreachable.
    function automatic int kmp_step(input int k, input bit b);
        int s;
        int len;
        int pos;
        bit ok;
        bit c;
        len = 0;
        if (k <= PAT_W) begin
            s = (k == PAT_W) ? RESTART : k;
            for (int j = 1; j <= s + 1; j++) begin
                ok = 1'b1;
                for (int t = 0; t < j; t++) begin
                    pos = s + 1 - j + t;
                    c   = (pos == s) ? b : pat_bit(pos);
                    if (c != pat_bit(t)) ok = 1'b0;
                end
                if (ok) len = j;
            end
        end
        return len;
    endfunction

    // Table indexed by {state, x}.
    logic [STATE_W-1:0] nxt_tab [TAB_N];

    for (genvar gi = 0; gi < TAB_N; gi++) begin : g_tab
        localparam int NXT = kmp_step(gi / 2, bit'(gi % 2));
        assign nxt_tab[gi] = STATE_W'(NXT);
    end

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               y_q;
    logic [STATE_W-1:0] step;
    logic               cnt_full;
    logic               match;

    assign step     = nxt_tab[{state_q, bus.x}];
    assign cnt_full = &cnt_q;
    assign match    = bus.en & ~bus.clr & (step == STATE_W'(PAT_W));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.clr) begin
            state_d = '0;
            cnt_d   = '0;
        end else if (bus.en) begin
            if (match) begin
                // Mealy already flagged the match this cycle, so skip the PAT_W state.
                state_d = MEALY ? STATE_W'(RESTART) : STATE_W'(PAT_W);
                if (!cnt_full) cnt_d = cnt_q + 1'b1;
            end else begin
                state_d = step;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            cnt_q   <= '0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= match;
        end
    end

    assign bus.y         = MEALY ? match : y_q;
    assign bus.state     = state_q;
    assign bus.match_cnt = cnt_q;
    assign bus.cnt_sat   = cnt_full;
endmodule

// File: tb/tb_seq_detect_fsm.sv
// Directed bench for seq_detect_fsm: four variants share one input stream
// (overlap/no-overlap Mealy, overlap Moore, 2-bit counter).
module tb_seq_detect_fsm;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic clr   = 1'b0;
    logic x     = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_detect_if #(.PAT_W(4), .CNT_W(8)) if_a ();
    seq_detect_if #(.PAT_W(4), .CNT_W(8)) if_b ();
    seq_detect_if #(.PAT_W(4), .CNT_W(8)) if_c ();
    seq_detect_if #(.PAT_W(4), .CNT_W(2)) if_d ();

    assign if_a.en = en;  assign if_a.clr = clr;  assign if_a.x = x;
    assign if_b.en = en;  assign if_b.clr = clr;  assign if_b.x = x;
    assign if_c.en = en;  assign if_c.clr = clr;  assign if_c.x = x;
    assign if_d.en = en;  assign if_d.clr = clr;  assign if_d.x = x;

    seq_detect_fsm #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MEALY(1'b1), .CNT_W(8))
        u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    seq_detect_fsm #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .MEALY(1'b1), .CNT_W(8))
        u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    seq_detect_fsm #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MEALY(1'b0), .CNT_W(8))
        u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));
    seq_detect_fsm #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .MEALY(1'b1), .CNT_W(2))
        u_d (.clk(clk), .rst_n(rst_n), .bus(if_d.slave));

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end else begin
            $display("ok   %s: %0d", tag, act);
        end
    endtask

    // Drive inputs on the falling edge so Mealy outputs can be sampled before the next rise.
    task automatic drive(input logic e, input logic c, input logic b);
        @(negedge clk);
        en  = e;
        clr = c;
        x   = b;
        #1;
    endtask

    task automatic clk_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        drive(1'b1, 1'b1, 1'b0);
        clk_edge();
    endtask

    logic       s_bits [7] = '{1, 0, 1, 1, 0, 1, 1};
    int         s_a    [7] = '{1, 2, 3, 1, 2, 3, 1};
    logic       y_a    [7] = '{0, 0, 0, 1, 0, 0, 1};
    int         s_b    [7] = '{1, 2, 3, 0, 0, 1, 1};
    logic       y_b    [7] = '{0, 0, 0, 1, 0, 0, 0};
    int         s_c    [7] = '{1, 2, 3, 4, 2, 3, 4};
    logic       y_c    [7] = '{0, 0, 0, 1, 0, 0, 1};
    logic       p_bits [4] = '{1, 0, 1, 1};

    initial begin
        // Reset state
        #12;
        check_eq("rst state_a", 32'(if_a.state), 0);
        check_eq("rst cnt_a", 32'(if_a.match_cnt), 0);
        check_eq("rst sat_a", 32'(if_a.cnt_sat), 0);
        check_eq("rst y_c", 32'(if_c.y), 0);
        rst_n = 1'b1;

        // Stream 1011011 on overlap Mealy, no-overlap Mealy and overlap Moore
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, s_bits[i]);
            check_eq($sformatf("t1 y_a bit%0d", i + 1), 32'(if_a.y), 32'(y_a[i]));
            check_eq($sformatf("t2 y_b bit%0d", i + 1), 32'(if_b.y), 32'(y_b[i]));
            clk_edge();
            check_eq($sformatf("t1 state_a bit%0d", i + 1), 32'(if_a.state), 32'(s_a[i]));
            check_eq($sformatf("t2 state_b bit%0d", i + 1), 32'(if_b.state), 32'(s_b[i]));
            check_eq($sformatf("t3 state_c bit%0d", i + 1), 32'(if_c.state), 32'(s_c[i]));
            check_eq($sformatf("t3 y_c bit%0d", i + 1), 32'(if_c.y), 32'(y_c[i]));
        end
        check_eq("t1 cnt_a", 32'(if_a.match_cnt), 2);
        check_eq("t2 cnt_b", 32'(if_b.match_cnt), 1);
        check_eq("t3 cnt_c", 32'(if_c.match_cnt), 2);

        // Enable gaps between bits 2 and 3
        do_clear();
        check_eq("t4 clr state_a", 32'(if_a.state), 0);
        check_eq("t4 clr cnt_a", 32'(if_a.match_cnt), 0);
        drive(1'b1, 1'b0, 1'b1); clk_edge();
        drive(1'b1, 1'b0, 1'b0); clk_edge();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            check_eq($sformatf("t4 hold y_a %0d", i), 32'(if_a.y), 0);
            clk_edge();
            check_eq($sformatf("t4 hold state_a %0d", i), 32'(if_a.state), 2);
            check_eq($sformatf("t4 hold state_c %0d", i), 32'(if_c.state), 2);
        end
        drive(1'b1, 1'b0, 1'b1); clk_edge();
        check_eq("t4 state_a bit3", 32'(if_a.state), 3);
        drive(1'b1, 1'b0, 1'b1);
        check_eq("t4 y_a bit4", 32'(if_a.y), 1);
        clk_edge();
        check_eq("t4 state_a bit4", 32'(if_a.state), 1);
        check_eq("t4 cnt_a", 32'(if_a.match_cnt), 1);
        check_eq("t4 state_c bit4", 32'(if_c.state), 4);
        check_eq("t4 y_c bit4", 32'(if_c.y), 1);
        // Moore flag drops after one cycle even with en low; state holds
        drive(1'b0, 1'b0, 1'b0); clk_edge();
        check_eq("t4 y_c en0", 32'(if_c.y), 0);
        check_eq("t4 state_c en0", 32'(if_c.state), 4);

        // Clear on the completing edge suppresses the match
        do_clear();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, p_bits[i]); clk_edge();
        end
        check_eq("t4c state_a pre", 32'(if_a.state), 3);
        drive(1'b1, 1'b1, 1'b1);
        check_eq("t4c y_a clr", 32'(if_a.y), 0);
        clk_edge();
        check_eq("t4c state_a clr", 32'(if_a.state), 0);
        check_eq("t4c cnt_a clr", 32'(if_a.match_cnt), 0);
        check_eq("t4c y_c clr", 32'(if_c.y), 0);

        // Saturating 2-bit counter
        do_clear();
        for (int m = 1; m <= 5; m++) begin
            for (int i = 0; i < 4; i++) begin
                drive(1'b1, 1'b0, p_bits[i]); clk_edge();
            end
            check_eq($sformatf("t5 cnt_d m%0d", m), 32'(if_d.match_cnt), (m < 3) ? m : 3);
            check_eq($sformatf("t5 sat_d m%0d", m), 32'(if_d.cnt_sat), (m >= 3) ? 1 : 0);
        end

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, p_bits[i]); clk_edge();
        end
        check_eq("t6 state_a pre", 32'(if_a.state), 3);
        rst_n = 1'b0;
        #2;
        check_eq("t6 state_a rst", 32'(if_a.state), 0);
        check_eq("t6 cnt_a rst", 32'(if_a.match_cnt), 0);
        check_eq("t6 cnt_d rst", 32'(if_d.match_cnt), 0);
        check_eq("t6 sat_d rst", 32'(if_d.cnt_sat), 0);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b1);
        check_eq("t6 y_a after", 32'(if_a.y), 0);
        clk_edge();
        check_eq("t6 state_a after", 32'(if_a.state), 1);
        check_eq("t6 y_c after", 32'(if_c.y), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
